// File: rtl/schedule_2nd.sv
// schedule_2nd: RAW scoreboard issue stage with per-register busy countdowns and upstream STALL.
// Define SCHEDULE_2ND_BYPASS_EN when EX forwarding covers the final countdown cycle.
module schedule_2nd #(
  parameter int ALU_LATENCY  = 3,
  parameter int LOAD_LATENCY = 5
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        FLUSH,
  input  logic        MEM_WAIT,
  input  logic [31:0] SCHEDULE_1ST_PC,
  input  logic [6:0]  SCHEDULE_1ST_OPCODE,
  input  logic [4:0]  SCHEDULE_1ST_RD,
  input  logic [4:0]  SCHEDULE_1ST_RS1,
  input  logic [4:0]  SCHEDULE_1ST_RS2,
  input  logic [2:0]  SCHEDULE_1ST_FUNCT3,
  input  logic [6:0]  SCHEDULE_1ST_FUNCT7,
  input  logic [31:0] SCHEDULE_1ST_IMM,
  output logic        STALL,
  output logic        SCHEDULE_2ND_VALID,
  output logic [31:0] SCHEDULE_2ND_PC,
  output logic [6:0]  SCHEDULE_2ND_OPCODE,
  output logic [4:0]  SCHEDULE_2ND_RD,
  output logic [4:0]  SCHEDULE_2ND_RS1,
  output logic [4:0]  SCHEDULE_2ND_RS2,
  output logic [2:0]  SCHEDULE_2ND_FUNCT3,
  output logic [6:0]  SCHEDULE_2ND_FUNCT7,
  output logic [31:0] SCHEDULE_2ND_IMM
);
  localparam int CW = $clog2(LOAD_LATENCY + 1);
  localparam logic [CW-1:0] ALU_LAT = CW'(ALU_LATENCY);
  localparam logic [CW-1:0] LOAD_LAT = CW'(LOAD_LATENCY);
  localparam logic [6:0] OP = 7'b0110011, OP_IMM = 7'b0010011, LOAD = 7'b0000011, STORE = 7'b0100011;
  localparam logic [6:0] BRANCH = 7'b1100011, JALR = 7'b1100111, LUI = 7'b0110111, AUIPC = 7'b0010111;
  localparam logic [6:0] JAL = 7'b1101111;
  logic [CW-1:0] cnt [1:31];
  logic [CW-1:0] cnt_nxt [1:31];
  logic [CW-1:0] dec [1:31];
  logic [31:0] busy_v;
  logic [CW-1:0] lat;
  logic valid_in, rs1_used, rs2_used, rd_wr, hazard, issue;
  logic [6:0] op;
  assign op = SCHEDULE_1ST_OPCODE;
  assign valid_in = |op;
  assign rs1_used = op == OP || op == OP_IMM || op == LOAD || op == STORE || op == BRANCH || op == JALR;
  assign rs2_used = op == OP || op == STORE || op == BRANCH;
  assign rd_wr = (op == OP || op == OP_IMM || op == LOAD || op == LUI || op == AUIPC || op == JAL || op == JALR)
                 && SCHEDULE_1ST_RD != 5'd0;
  assign hazard = valid_in & ((rs1_used & busy_v[SCHEDULE_1ST_RS1]) | (rs2_used & busy_v[SCHEDULE_1ST_RS2]));
  assign STALL = hazard & ~FLUSH & ~RST;
  // a flushed instruction must never claim its destination register
  assign issue = valid_in & ~hazard & ~FLUSH;
  assign lat = op == LOAD ? LOAD_LAT : ALU_LAT;
  always_comb begin
    busy_v = '0;
    for (int i = 1; i < 32; i++) begin
`ifdef SCHEDULE_2ND_BYPASS_EN
      busy_v[i] = cnt[i] > CW'(1);
`else
      busy_v[i] = cnt[i] != '0;
`endif
      dec[i] = cnt[i] != '0 ? cnt[i] - CW'(1) : '0;
      cnt_nxt[i] = (issue && rd_wr && SCHEDULE_1ST_RD == 5'(i) && lat > dec[i]) ? lat : dec[i];
    end
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt <= '{default: '0};
      SCHEDULE_2ND_VALID <= 1'b0;
      SCHEDULE_2ND_PC <= '0;
      SCHEDULE_2ND_OPCODE <= '0;
      SCHEDULE_2ND_RD <= '0;
      SCHEDULE_2ND_RS1 <= '0;
      SCHEDULE_2ND_RS2 <= '0;
      SCHEDULE_2ND_FUNCT3 <= '0;
      SCHEDULE_2ND_FUNCT7 <= '0;
      SCHEDULE_2ND_IMM <= '0;
    end else if (FLUSH || !MEM_WAIT) begin
      cnt <= cnt_nxt;
      SCHEDULE_2ND_VALID <= issue;
      SCHEDULE_2ND_PC <= issue ? SCHEDULE_1ST_PC : '0;
      SCHEDULE_2ND_OPCODE <= issue ? SCHEDULE_1ST_OPCODE : '0;
      SCHEDULE_2ND_RD <= issue ? SCHEDULE_1ST_RD : '0;
      SCHEDULE_2ND_RS1 <= issue ? SCHEDULE_1ST_RS1 : '0;
      SCHEDULE_2ND_RS2 <= issue ? SCHEDULE_1ST_RS2 : '0;
      SCHEDULE_2ND_FUNCT3 <= issue ? SCHEDULE_1ST_FUNCT3 : '0;
      SCHEDULE_2ND_FUNCT7 <= issue ? SCHEDULE_1ST_FUNCT7 : '0;
      SCHEDULE_2ND_IMM <= issue ? SCHEDULE_1ST_IMM : '0;
    end
  end
endmodule

// File: tb/tb_schedule_2nd.sv
// tb_schedule_2nd: per-cycle vector table checking STALL and registered issue fields.
module tb_schedule_2nd;
  localparam logic [6:0] OP = 7'b0110011, OPI = 7'b0010011, LD = 7'b0000011, ST = 7'b0100011;
`ifdef SCHEDULE_2ND_BYPASS_EN
  localparam int ALU_ST = 2, LD_ST = 4;
`else
  localparam int ALU_ST = 3, LD_ST = 5;
`endif
  logic CLK = 1'b0, RST = 1'b1, FLUSH = 1'b0, MEM_WAIT = 1'b0;
  logic [31:0] pc_i = '0, imm_i = '0;
  logic [6:0] op_i = '0, f7_i = '0;
  logic [4:0] rd_i = '0, rs1_i = '0, rs2_i = '0;
  logic [2:0] f3_i = '0;
  logic stall, valid;
  logic [31:0] pc_o, imm_o;
  logic [6:0] op_o, f7_o;
  logic [4:0] rd_o, rs1_o, rs2_o;
  logic [2:0] f3_o;
  typedef struct {
    logic r, f, m;
    logic [6:0] op;
    logic [4:0] rd, rs1, rs2;
    logic [31:0] pc;
    logic es, ev;
    logic [6:0] eop;
    logic [4:0] erd, ers1, ers2;
    logic [31:0] epc;
  } vec_t;
  vec_t q[$];
  int total = 0, bad = 0;
  schedule_2nd dut (
    .CLK(CLK), .RST(RST), .FLUSH(FLUSH), .MEM_WAIT(MEM_WAIT),
    .SCHEDULE_1ST_PC(pc_i), .SCHEDULE_1ST_OPCODE(op_i), .SCHEDULE_1ST_RD(rd_i),
    .SCHEDULE_1ST_RS1(rs1_i), .SCHEDULE_1ST_RS2(rs2_i), .SCHEDULE_1ST_FUNCT3(f3_i),
    .SCHEDULE_1ST_FUNCT7(f7_i), .SCHEDULE_1ST_IMM(imm_i),
    .STALL(stall), .SCHEDULE_2ND_VALID(valid), .SCHEDULE_2ND_PC(pc_o),
    .SCHEDULE_2ND_OPCODE(op_o), .SCHEDULE_2ND_RD(rd_o), .SCHEDULE_2ND_RS1(rs1_o),
    .SCHEDULE_2ND_RS2(rs2_o), .SCHEDULE_2ND_FUNCT3(f3_o), .SCHEDULE_2ND_FUNCT7(f7_o),
    .SCHEDULE_2ND_IMM(imm_o)
  );
  always #5 CLK = ~CLK;
  // es: STALL expected during this row; iss: row issues; MEM_WAIT rows expect the previous outputs held
  task automatic add(input logic r, f, m, input logic [6:0] op, input logic [4:0] rd, rs1, rs2,
                     input logic [31:0] pc, input logic es, iss);
    vec_t v;
    v.r = r; v.f = f; v.m = m; v.op = op; v.rd = rd; v.rs1 = rs1; v.rs2 = rs2; v.pc = pc;
    v.es = es; v.ev = iss;
    v.eop = '0; v.erd = '0; v.ers1 = '0; v.ers2 = '0; v.epc = '0;
    if (iss) begin
      v.eop = op; v.erd = rd; v.ers1 = rs1; v.ers2 = rs2; v.epc = pc;
    end else if (m && !r && !f && q.size() > 0) begin
      v.ev = q[$].ev; v.eop = q[$].eop; v.erd = q[$].erd; v.ers1 = q[$].ers1; v.ers2 = q[$].ers2;
      v.epc = q[$].epc;
    end
    q.push_back(v);
  endtask
  task automatic iss(input logic [6:0] op, input logic [4:0] rd, rs1, rs2, input logic [31:0] pc);
    add(0, 0, 0, op, rd, rs1, rs2, pc, 0, 1);
  endtask
  task automatic stl(input logic [6:0] op, input logic [4:0] rd, rs1, rs2, input logic [31:0] pc);
    add(0, 0, 0, op, rd, rs1, rs2, pc, 1, 0);
  endtask
  task automatic bub(input int n);
    repeat (n) add(0, 0, 0, '0, '0, '0, '0, '0, 0, 0);
  endtask
  task automatic chk(input string name, input logic [127:0] act, exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask
  initial begin
    add(1, 0, 0, OP, 5'd3, 5'd1, 5'd2, $urandom, 0, 0);
    add(1, 0, 1, OPI, 5'd5, 5'd4, 5'd6, $urandom, 0, 0);
    bub(1);
    iss(OPI, 5, 0, 0, 'h100);
    repeat (ALU_ST) stl(OP, 6, 5, 5, 'h104);
    iss(OP, 6, 5, 5, 'h104);
    bub(6);
    iss(LD, 7, 1, 0, 'h200);
    repeat (LD_ST) stl(OP, 8, 7, 0, 'h204);
    iss(OP, 8, 7, 0, 'h204);
    iss(LD, 7, 1, 0, 'h210);
    repeat (LD_ST) stl(ST, 4, 1, 7, 'h214);
    iss(ST, 4, 1, 7, 'h214);
    iss(OP, 11, 4, 4, 'h218);
    bub(6);
    iss(OPI, 0, 0, 0, 'h300);
    iss(OP, 1, 0, 0, 'h304);
    bub(6);
    iss(OPI, 5, 0, 0, 'h500);
    add(0, 0, 1, OP, 6, 5, 5, 'h504, 1, 0);
    stl(OP, 6, 5, 5, 'h504);
    repeat (3) add(0, 0, 1, OP, 6, 5, 5, 'h504, 1, 0);
    repeat (ALU_ST - 1) stl(OP, 6, 5, 5, 'h504);
    iss(OP, 6, 5, 5, 'h504);
    bub(6);
    iss(OPI, 5, 0, 0, 'h600);
    stl(OP, 6, 5, 5, 'h604);
    add(0, 1, 0, OP, 6, 5, 5, 'h604, 0, 0);
    repeat (ALU_ST - 2) stl(OP, 6, 5, 5, 'h620);
    iss(OP, 6, 5, 5, 'h620);
    add(0, 1, 0, OPI, 12, 0, 0, 'h630, 0, 0);
    iss(OP, 13, 12, 12, 'h634);
    bub(6);
    iss(LD, 9, 0, 0, 'h700);
    iss(OPI, 9, 0, 0, 'h704);
    repeat (LD_ST - 1) stl(OP, 10, 9, 0, 'h708);
    iss(OP, 10, 9, 0, 'h708);
    bub(6);
    iss(OPI, 5, 0, 0, 'h800);
    add(1, 0, 0, OP, 6, 5, 5, 'h804, 0, 0);
    iss(OP, 6, 5, 5, 'h808);
    bub(1);
    foreach (q[i]) begin
      @(negedge CLK);
      RST = q[i].r; FLUSH = q[i].f; MEM_WAIT = q[i].m;
      op_i = q[i].op; rd_i = q[i].rd; rs1_i = q[i].rs1; rs2_i = q[i].rs2; pc_i = q[i].pc;
      f3_i = q[i].pc[2:0]; f7_i = q[i].pc[9:3]; imm_i = q[i].pc * 32'd3;
      #1;
      chk($sformatf("stall[%0d]", i), 128'(stall), 128'(q[i].es));
      @(posedge CLK);
      #1;
      chk($sformatf("valid[%0d]", i), 128'(valid), 128'(q[i].ev));
      chk($sformatf("fields[%0d]", i),
          128'({op_o, rd_o, rs1_o, rs2_o, f3_o, f7_o, imm_o, pc_o}),
          128'({q[i].eop, q[i].erd, q[i].ers1, q[i].ers2, q[i].epc[2:0], q[i].epc[9:3],
                q[i].epc * 32'd3, q[i].epc}));
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
